// File: rtl/shift_unit_if.sv
// Valid/ready operand and result channel between the execute stage and shift_unit.
// The execute stage drives the master modport; the shifter implements the slave modport.
interface shift_unit_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               busy;

  modport master (
    output in_valid, operand, shamt, op, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, operand, shamt, op, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/shift_unit.sv
// Iterative log-stage shifter (SLL/SRL/SRA/ROR): one power-of-two stage per clock.
// Define SHIFT_EARLY_EXIT_EN to skip trailing stages whose shamt bits are zero.
module shift_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clock,
  input logic         reset,
  shift_unit_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic               last_stage;

  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] v, input op_e o,
                                                   input logic [SHAMT_W-1:0] a);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v} >> a;
    case (o)
      OP_SLL:  return v << a;
      OP_SRL:  return v >> a;
      OP_SRA:  return $signed(v) >>> a;
      default: return dbl[WIDTH-1:0];
    endcase
  endfunction

  // Stage index k is held as its weight amt_q = 2^k; rem_q is shamt shifted right by k,
  // so rem_q[0] is shamt[k] and rem_q[SHAMT_W-1:1] is shamt[SHAMT_W-1:k+1].
`ifdef SHIFT_EARLY_EXIT_EN
  assign last_stage = ((rem_q >> 1) == '0);
`else
  assign last_stage = amt_q[SHAMT_W-1];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_SLL;
      work_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      amt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      amt_q    <= amt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef SHIFT_EARLY_EXIT_EN
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT:   if (last_stage) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    work_d   = work_q;
    result_d = result_q;
    rem_d    = rem_q;
    amt_d    = amt_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.operand;
          rem_d  = bus.shamt;
          amt_d  = SHAMT_W'(1);
          op_d   = op_e'(bus.op);
          if (state_d == DONE) result_d = bus.operand;
        end
      end
      SHIFT: begin
        if (rem_q[0]) work_d = stage_shift(work_q, op_q, amt_q);
        rem_d = rem_q >> 1;
        amt_d = amt_q << 1;
        if (state_d == DONE) result_d = work_d;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = result_q;
  end
endmodule
